// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order reorder buffer. Dispatch allocates one entry per cycle at
//   the tail, recording the destination physical register. Commit retires one
//   entry per cycle from the head and reports the retired tag so the free list
//   and architectural map can be updated.
//
// Optional feature macro: ROB_ERR_EN
//   When defined, adds a sticky `err` output (set after a rejected push or pop)
//   and simulation assertions on the same conditions.
//
// Parameters
//   DEPTH   number of entries (>= 2, any integer)
//   PHYS_W  physical register tag width
//   IDX_W   derived entry index width, $clog2(DEPTH)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   push          allocate request, writes dst_phys into the tail entry
//   dst_phys      destination physical register of the dispatched instruction
//   pop           commit request, retires the head entry
//   full          count == DEPTH
//   empty         count == 0
//   count         number of valid entries
//   alloc_idx     tail index an accepted push will write
//   head_phys     tag of the head entry, 0 when empty
//   commit_valid  registered one-cycle pulse for an accepted pop
//   commit_phys   registered tag of the entry just retired (holds otherwise)
//   err           sticky rejected-request flag (ROB_ERR_EN only)
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter  int DEPTH  = 16,
  parameter  int PHYS_W = 6,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PHYS_W-1:0] dst_phys,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [IDX_W:0]    count,
  output logic [IDX_W-1:0]  alloc_idx,
  output logic [PHYS_W-1:0] head_phys,
  output logic              commit_valid,
  output logic [PHYS_W-1:0] commit_phys
`ifdef ROB_ERR_EN
  ,
  output logic              err
`endif
);

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  logic [DEPTH-1:0]  valid_q;
  logic [PHYS_W-1:0] phys_mem [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [IDX_W:0]    count_q;

  logic pop_acc;
  logic push_acc;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign alloc_idx = tail_q;
  assign head_phys = valid_q[head_q] ? phys_mem[head_q] : '0;

  // A pop frees the head slot in the same cycle, so a full buffer can still
  // accept a push alongside it.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets a simultaneous push and pop on
  // a full buffer read the old head before the tail write lands on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      commit_valid <= 1'b0;
      commit_phys  <= '0;
    end else begin
      commit_valid <= pop_acc;
      if (pop_acc) begin
        valid_q[head_q] <= 1'b0;
        commit_phys     <= phys_mem[head_q];
        head_q          <= next_idx(head_q);
      end
      // Placed after the pop clear: when full, head == tail and the new entry
      // must win the valid bit.
      if (push_acc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= next_idx(tail_q);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the tag storage is deliberately not reset; every read is qualified
  // by a reset valid bit, so clearing it would only cost a reset network.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      phys_mem[tail_q] <= dst_phys;
    end
  end

`ifdef ROB_ERR_EN
  logic push_rej;
  logic pop_rej;

  // A pop on an empty buffer alongside a push is absorbed by the push and is
  // not treated as an error.
  assign push_rej = push && full && !pop;
  assign pop_rej  = pop && empty && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (push_rej || pop_rej) begin
      err <= 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !push_rej)
    else $error("reorder_buffer: push while full");
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !pop_rej)
    else $error("reorder_buffer: pop while empty");
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed self-checking bench for reorder_buffer (DEPTH=16, PHYS_W=6).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int PHYS_W = 6;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic [PHYS_W-1:0] dst_phys;
  logic              pop;
  logic              full;
  logic              empty;
  logic [IDX_W:0]    count;
  logic [IDX_W-1:0]  alloc_idx;
  logic [PHYS_W-1:0] head_phys;
  logic              commit_valid;
  logic [PHYS_W-1:0] commit_phys;
`ifdef ROB_ERR_EN
  logic              err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .PHYS_W(PHYS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .dst_phys     (dst_phys),
    .pop          (pop),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .alloc_idx    (alloc_idx),
    .head_phys    (head_phys),
    .commit_valid (commit_valid),
    .commit_phys  (commit_phys)
`ifdef ROB_ERR_EN
    ,
    .err          (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs applied; returns 1 unit after the edge.
  // When not pushing, dst_phys gets junk to show it is ignored.
  task automatic step(input logic r, input logic pu, input logic [PHYS_W-1:0] tag,
                      input logic po);
    rst      = r;
    push     = pu;
    dst_phys = pu ? tag : PHYS_W'($urandom);
    pop      = po;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic fill_0_to_15();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, PHYS_W'(i), 1'b0);
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; dst_phys = '0;
    #1;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst_count",     32'(count), 0);
    check("rst_empty",     32'(empty), 1);
    check("rst_full",      32'(full), 0);
    check("rst_alloc",     32'(alloc_idx), 0);
    check("rst_head",      32'(head_phys), 0);
    check("rst_cvalid",    32'(commit_valid), 0);
    check("rst_cphys",     32'(commit_phys), 0);

    // Push 10 then 11
    step(1'b0, 1'b1, 6'd10, 1'b0);
    check("p1_count",      32'(count), 1);
    check("p1_head",       32'(head_phys), 10);
    check("p1_alloc",      32'(alloc_idx), 1);
    step(1'b0, 1'b1, 6'd11, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("p2_count",      32'(count), 2);
    check("p2_head",       32'(head_phys), 10);
    check("p2_alloc",      32'(alloc_idx), 2);
    check("p2_empty",      32'(empty), 0);
    check("p2_cvalid",     32'(commit_valid), 0);

    // Single pop
    step(1'b0, 1'b0, '0, 1'b1);
    check("pop_cvalid",    32'(commit_valid), 1);
    check("pop_cphys",     32'(commit_phys), 10);
    check("pop_count",     32'(count), 1);
    check("pop_head",      32'(head_phys), 11);
    step(1'b0, 1'b0, '0, 1'b0);
    check("pop_pulse_end", 32'(commit_valid), 0);
    check("pop_cphys_hold",32'(commit_phys), 10);

    // Fill, overflow push, drain
    step(1'b1, 1'b0, '0, 1'b0);
    fill_0_to_15();
    check("fill_full",     32'(full), 1);
    check("fill_count",    32'(count), 16);
    check("fill_alloc",    32'(alloc_idx), 0);
    step(1'b0, 1'b1, 6'd63, 1'b0);
    check("ovf_full",      32'(full), 1);
    check("ovf_count",     32'(count), 16);
    check("ovf_head",      32'(head_phys), 0);
    check("ovf_cvalid",    32'(commit_valid), 0);
`ifdef ROB_ERR_EN
    check("ovf_err",       32'(err), 1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check($sformatf("drain_cv%0d", i), 32'(commit_valid), 1);
      check($sformatf("drain_cp%0d", i), 32'(commit_phys), 32'(i));
    end
    check("drain_empty",   32'(empty), 1);
    check("drain_head",    32'(head_phys), 0);

    // Push + pop while full, then drain across the wrap
    step(1'b1, 1'b0, '0, 1'b0);
    fill_0_to_15();
    step(1'b0, 1'b1, 6'd40, 1'b1);
    check("fpp_cvalid",    32'(commit_valid), 1);
    check("fpp_cphys",     32'(commit_phys), 0);
    check("fpp_count",     32'(count), 16);
    check("fpp_full",      32'(full), 1);
    check("fpp_head",      32'(head_phys), 1);
    check("fpp_alloc",     32'(alloc_idx), 1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check($sformatf("wrap_cp%0d", i), 32'(commit_phys), (i == DEPTH) ? 40 : 32'(i));
    end
    check("wrap_empty",    32'(empty), 1);

    // Pop while empty, then push + pop while empty
`ifdef ROB_ERR_EN
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 6'd7, 1'b1);
    check("epp_err_clear", 32'(err), 0);
    step(1'b1, 1'b0, '0, 1'b0);
`endif
    step(1'b0, 1'b0, '0, 1'b1);
    check("epop_cvalid",   32'(commit_valid), 0);
    check("epop_count",    32'(count), 0);
`ifdef ROB_ERR_EN
    check("epop_err",      32'(err), 1);
`endif
    step(1'b0, 1'b1, 6'd7, 1'b1);
    check("epp_cvalid",    32'(commit_valid), 0);
    check("epp_count",     32'(count), 1);
    check("epp_head",      32'(head_phys), 7);

    // Reset with entries held and a pop in flight
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, PHYS_W'(20 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("mid_cvalid",    32'(commit_valid), 1);
    check("mid_count",     32'(count), 4);
    step(1'b1, 1'b1, 6'd33, 1'b1);
    check("mrst_count",    32'(count), 0);
    check("mrst_cvalid",   32'(commit_valid), 0);
    check("mrst_cphys",    32'(commit_phys), 0);
    check("mrst_head",     32'(head_phys), 0);
    check("mrst_empty",    32'(empty), 1);
    check("mrst_alloc",    32'(alloc_idx), 0);
`ifdef ROB_ERR_EN
    check("mrst_err",      32'(err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
